// File: rtl/genesis_pad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : genesis_pad_scanner_if
//  Purpose  : Bundles the pad-facing pins and the frame-coherent result bus
//             of the Genesis multi-port pad scanner.
//  Signals  : pad_pins     raw active-low pad pins, 6 per port
//             select       select line per port (all bits identical)
//             buttons      committed pressed buttons, 12 per port
//             pressed_edge newly pressed buttons, valid with frame_valid
//             present      pad detected on the last committed scan
//             six_button   pad identified as 6-button
//             frame_valid  one-cycle pulse when results update
//  Modports : master - the scanner (drives select and results)
//             slave  - the board/consumer side (drives pad_pins)
//  Revision : 1.0 - initial release
// ============================================================================
interface genesis_pad_scanner_if #(
  parameter int NUM_PADS = 2
);
  logic [6*NUM_PADS-1:0]  pad_pins;
  logic [NUM_PADS-1:0]    select;
  logic [12*NUM_PADS-1:0] buttons;
  logic [12*NUM_PADS-1:0] pressed_edge;
  logic [NUM_PADS-1:0]    present;
  logic [NUM_PADS-1:0]    six_button;
  logic                   frame_valid;

  modport master (
    input  pad_pins,
    output select, buttons, pressed_edge, present, six_button, frame_valid
  );

  modport slave (
    output pad_pins,
    input  select, buttons, pressed_edge, present, six_button, frame_valid
  );
endinterface
`default_nettype wire

// File: rtl/genesis_pad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : genesis_pad_scanner
//  Purpose  : Once per video frame (falling edge of vga_vs) runs an 8-phase
//             select sequence shared by NUM_PADS Mega Drive/Genesis ports,
//             decodes 12 buttons per port, detects presence and 3/6-button
//             type, and publishes a frame-coherent snapshot plus press edges.
//  Ports    : clock_50 - system clock
//             reset    - asynchronous active-low reset
//             vga_vs   - vertical sync (asynchronous), falling edge = scan
//             bus      - genesis_pad_scanner_if.master (pins, select, results)
//  Revision : 1.0 - initial release
// ============================================================================
module genesis_pad_scanner #(
  parameter int NUM_PADS     = 2,
  parameter int PHASE_CYCLES = 1000
) (
  input  logic                  clock_50,
  input  logic                  reset,
  input  logic                  vga_vs,
  genesis_pad_scanner_if.master bus
);

  localparam int            CW     = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [3:0] S_P0   = 4'd0;
  localparam logic [3:0] S_P1   = 4'd1;
  localparam logic [3:0] S_P5   = 4'd5;
  localparam logic [3:0] S_P6   = 4'd6;
  localparam logic [3:0] S_P7   = 4'd7;
  localparam logic [3:0] S_IDLE = 4'd8;

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic                  r_vs_s1, r_vs_s2, r_vs_prev;
  logic [6*NUM_PADS-1:0] r_pins_s1, r_pins_s2;

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      // vsync history resets low so a high vga_vs at release is not an edge
      r_vs_s1   <= 1'b0;
      r_vs_s2   <= 1'b0;
      r_vs_prev <= 1'b0;
      r_pins_s1 <= '1;
      r_pins_s2 <= '1;
    end else begin
      r_vs_s1   <= vga_vs;
      r_vs_s2   <= r_vs_s1;
      r_vs_prev <= r_vs_s2;
      r_pins_s1 <= bus.pad_pins;
      r_pins_s2 <= r_pins_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Phase sequencer
  // --------------------------------------------------------------------------
  logic [3:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [NUM_PADS-1:0] r_select;
  logic                r_fv;

  logic       w_vs_fall;
  logic       w_phase_end;
  logic       w_start;
  logic       w_commit;
  logic [3:0] w_state_nxt;
  logic       w_sel_nxt;

  assign w_vs_fall   = r_vs_prev & ~r_vs_s2;
  assign w_phase_end = (r_cnt == C_LAST);
  // Triggers are only honoured in IDLE; edges during a scan are dropped.
  assign w_start     = (r_state == S_IDLE) && w_vs_fall;
  assign w_commit    = (r_state == S_P7) && w_phase_end;

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_P0;
    end else if (r_state != S_IDLE && w_phase_end) begin
      w_state_nxt = (r_state == S_P7) ? S_IDLE : r_state + 4'd1;
    end
  end

  // select is derived from the next state so it is aligned with the phase
  assign w_sel_nxt = (w_state_nxt == S_IDLE) || !w_state_nxt[0];

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_select <= '1;
      r_fv     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_select <= {NUM_PADS{w_sel_nxt}};
      r_fv     <= w_commit;
      if (r_state == S_IDLE || w_phase_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_ONE;
      end
    end
  end

  assign bus.select      = r_select;
  assign bus.frame_valid = r_fv;

  // --------------------------------------------------------------------------
  // Per-port capture and commit
  // Button layout: {Up,Down,Left,Right,A,B,C,Start,X,Y,Z,Mode} = [11:0]
  // Pin layout   : {Pino9,Pino6,Pino4,Pino3,Pino2,Pino1}       = [5:0]
  // --------------------------------------------------------------------------
  generate
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      logic [5:0]  w_pins;
      logic        w_p1, w_p2, w_p3, w_p4, w_p6, w_p9;
      logic [11:0] w_new;

      logic [11:0] r_sh_btn;
      logic        r_sh_present;
      logic        r_sh_six;
      logic [11:0] r_btn;
      logic [11:0] r_edge;
      logic        r_present;
      logic        r_six;

      assign w_pins = r_pins_s2[6*p +: 6];
      assign w_p1   = w_pins[0];
      assign w_p2   = w_pins[1];
      assign w_p3   = w_pins[2];
      assign w_p4   = w_pins[3];
      assign w_p6   = w_pins[4];
      assign w_p9   = w_pins[5];

      // Absent pads report nothing; 3-button pads never report X/Y/Z/Mode.
      always_comb begin
        w_new = '0;
        if (r_sh_present) begin
          w_new = r_sh_six ? r_sh_btn : {r_sh_btn[11:4], 4'b0000};
        end
      end

      always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
          r_sh_btn     <= '0;
          r_sh_present <= 1'b0;
          r_sh_six     <= 1'b0;
          r_btn        <= '0;
          r_edge       <= '0;
          r_present    <= 1'b0;
          r_six        <= 1'b0;
        end else begin
          if (w_start) begin
            r_sh_btn     <= '0;
            r_sh_present <= 1'b0;
            r_sh_six     <= 1'b0;
          end else if (w_phase_end) begin
            case (r_state)
              S_P0: begin
                r_sh_btn[11] <= ~w_p1;
                r_sh_btn[10] <= ~w_p2;
                r_sh_btn[9]  <= ~w_p3;
                r_sh_btn[8]  <= ~w_p4;
                r_sh_btn[6]  <= ~w_p6;
                r_sh_btn[5]  <= ~w_p9;
              end
              S_P1: begin
                // A pad grounds Pino3/Pino4 while select is low
                r_sh_present <= ~w_p3 & ~w_p4;
                r_sh_btn[7]  <= ~w_p6;
                r_sh_btn[4]  <= ~w_p9;
              end
              S_P5: begin
                // Third low pulse: a 6-button pad grounds Pino1..Pino4
                r_sh_six <= ~(w_p1 | w_p2 | w_p3 | w_p4);
              end
              S_P6: begin
                if (r_sh_six) begin
                  r_sh_btn[1] <= ~w_p1;
                  r_sh_btn[2] <= ~w_p2;
                  r_sh_btn[3] <= ~w_p3;
                  r_sh_btn[0] <= ~w_p4;
                end
              end
              default: begin
              end
            endcase
          end

          if (w_commit) begin
            r_btn     <= w_new;
            r_edge    <= w_new & ~r_btn;
            r_present <= r_sh_present;
            r_six     <= r_sh_present & r_sh_six;
          end else begin
            r_edge    <= '0;
          end
        end
      end

      assign bus.buttons[12*p +: 12]      = r_btn;
      assign bus.pressed_edge[12*p +: 12] = r_edge;
      assign bus.present[p]               = r_present;
      assign bus.six_button[p]            = r_six;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/genesis_pad_scanner.md
# genesis_pad_scanner

Multi-port successor to the single-pad Mega Drive/Genesis controller reader. Once per video frame, triggered by the falling edge of `vga_vs`, it runs an 8-phase select sequence shared by `NUM_PADS` controller ports. For each port it decodes the 12 buttons, detects pad presence and 3- vs 6-button type, and publishes an atomic, frame-coherent button snapshot plus one-cycle press-edge pulses to the game/robot logic.

## Interface
- `NUM_PADS`, default 2: number of controller ports, 1..4.
- `PHASE_CYCLES`, default 1000: clock cycles per select phase, ≥ 8; counter width `$clog2(PHASE_CYCLES)`.
- `clock_50`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `vga_vs`  in  1  vertical sync, asynchronous to the scan; its falling edge starts a scan.
- `pad_pins`  in  6*NUM_PADS  raw pad pins. Per pad p, bits [6p+5:6p] = {Pino9, Pino6, Pino4, Pino3, Pino2, Pino1}, active-low, pulled up.
- `select`  out  NUM_PADS  select line per port. All bits are identical.
- `buttons`  out  12*NUM_PADS  pressed = 1. Per pad bits [12p+11:12p] = {Up, Down, Left, Right, A, B, C, Start, X, Y, Z, Mode}.
- `pressed_edge`  out  12*NUM_PADS  newly pressed bits, same layout. Valid only while `frame_valid` = 1.
- `present`  out  NUM_PADS  pad detected on the last committed scan.
- `six_button`  out  NUM_PADS  pad identified as 6-button on the last committed scan.
- `frame_valid`  out  1  one-cycle pulse when the outputs update.

## Operation
- **Synchronisation:** `vga_vs` and all `pad_pins` pass through 2-FF synchronisers. Falling edge = synced previous 1, synced current 0.
- **States:** IDLE, then P0..P7, then back to IDLE. Phase counter counts 0..PHASE_CYCLES-1 within each phase.
- **`select` value:** 1 in IDLE, P0, P2, P4, P6. 0 in P1, P3, P5, P7. `select` is registered.
- **IDLE → P0:** on a detected falling edge. Falling edges seen during P0..P7 are ignored, not queued.
- **Sampling:** each pad's synced pins are captured on the last cycle of a phase (counter = PHASE_CYCLES-1) into shadow registers, inverted to active-high:
  - P0: Up=!Pino1, Down=!Pino2, Left=!Pino3, Right=!Pino4, B=!Pino6, C=!Pino9.
  - P1: present_sh = (Pino3==0 && Pino4==0); A=!Pino6, Start=!Pino9.
  - P5: six_sh = (Pino1..Pino4 all 0).
  - P6: if six_sh, then Z=!Pino1, Y=!Pino2, X=!Pino3, Mode=!Pino4.
  - P2, P3, P4, P7: no capture.
- **Commit:** on the last cycle of P7, all ports commit simultaneously:
  - `present` ← present_sh.
  - `six_button` ← present_sh & six_sh.
  - `buttons` ← shadow, masked as follows: all 12 bits forced to 0 if not present; X/Y/Z/Mode forced to 0 if not six-button.
  - `pressed_edge` ← new & ~old, where old = previous committed `buttons`.
  - The FSM returns to IDLE.
- Shadow registers are cleared at scan start (IDLE → P0).
- `pressed_edge` is 0 in every cycle except the `frame_valid` cycle.

## Timing
- **Reset** (asynchronous assert, synchronous-safe release):
  - State IDLE, counters 0, shadows 0.
  - `select` = all 1s.
  - `buttons`, `pressed_edge`, `present`, `six_button`, `frame_valid` = 0.
  - Edge history = 0: the first scan after reset reports every held button as an edge.
- **Start latency:** a `vga_vs` falling edge at the pins produces the first P0 cycle 3 cycles later (2 sync stages + edge register).
- **Scan length:** exactly 8*PHASE_CYCLES cycles from the first P0 cycle to the last P7 cycle.
- **Output update:** `frame_valid`, `buttons`, `pressed_edge`, `present`, `six_button` all change in the cycle after the last P7 cycle. `buttons`, `present`, `six_button` then hold until the next commit.
- **Edge on the last P7 cycle:** a falling edge detected in the same cycle the FSM re-enters IDLE is ignored. Detection is evaluated only while in IDLE.
- **Reset mid-scan:** aborts the scan. No `frame_valid`, outputs return to reset values.
- **Pad changes between phases:** allowed. Each field reflects only its own phase's sample.

## Test plan
- **3-button, Up + A held:** NUM_PADS=1, PHASE_CYCLES=16; 3-button model; vs fall → `buttons`=0x880, `present`=1, `six_button`=0, `pressed_edge`=0x880, `frame_valid` exactly 3+128 cycles after the vs fall.
- **6-button, Z + Mode held:** 6-button model → `buttons`=0x003, `six_button`=1. A 3-button model driving the same pins in P6 → `buttons`=0x000.
- **Disconnected port:** all pins held 1 → `present`=0, `buttons`=0, `select` toggles H,L,H,L,H,L,H,L, 16 cycles each.
- **Edge history:** B held across two frames → `pressed_edge` bit 6 set on the first `frame_valid` only. Release and re-press → set again.
- **Ignored trigger and reset mid-scan:** second vs fall at P3 → scan still 128 cycles, only one `frame_valid`. `reset` low in P4 → `select`=1, all outputs 0 immediately, no `frame_valid`.
- **Two ports:** NUM_PADS=2, pad0 3-button with C held, pad1 6-button with X held → `buttons`=0x008_020, `six_button`=2'b10, `present`=2'b11.
